// File: rtl/tb_sched_pkg.sv
// Shared definitions for the TB buffer read schedulers: direction and target
// codes, scheduler FSM states and the {target, dir, lk0} select word.
package tb_sched_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;
    localparam logic [1:0] DIR_NEW  = 2'b11;

    localparam logic TBa_A = 1'b0;
    localparam logic TBa_M = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    typedef struct packed {
        logic       target;
        logic [1:0] dir;
        logic       lk0;
    } sel_t;

endpackage

// File: rtl/tb_sel_delay.sv
// RD_LAT-stage shift register for the select word, so the mapping stage sees
// the select in the same cycle the BRAM returns the row.
module tb_sel_delay
    import tb_sched_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  sel_t i_sel,
    output sel_t o_sel
);

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            sel_t w_d;
            sel_t r_q;

            if (gi == 0) begin : g_head
                assign w_d = i_sel;
            end else begin : g_tail
                assign w_d = g_stage[gi-1].r_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_d;
                end
            end
        end
    endgenerate

    assign o_sel = g_stage[RD_LAT-1].r_q;

endmodule

// File: rtl/tb_rd_sched.sv
// TB port-A read scheduler: arbitrates A/M row-block commands, issues reads and
// aligns the output select with read data. Define TB_RD_SCHED_RR_EN for round-robin.
module tb_rd_sched
    import tb_sched_pkg::*;
#(
    parameter int TB_AW  = 10,
    parameter int CNT_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [TB_AW-1:0] a_req_addr,
    input  logic [CNT_W-1:0] a_req_len,
    input  logic [1:0]       a_req_dir,
    input  logic             a_req_lk0,
    input  logic             m_req_valid,
    output logic             m_req_ready,
    input  logic [TB_AW-1:0] m_req_addr,
    input  logic [CNT_W-1:0] m_req_len,
    input  logic [1:0]       m_req_dir,
    input  logic             m_req_lk0,
    output logic             TB_ena,
    output logic [TB_AW-1:0] TB_addra,
    output logic [2:0]       TB_douta_sel,
    output logic             l_k_0,
    output logic             a_done,
    output logic             m_done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       DRAIN_LAST = 3'(RD_LAT);

    state_t           r_state;
    logic [TB_AW-1:0] r_base;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dir;
    logic             r_lk0;
    logic             r_tgt;
    logic [2:0]       r_drain;

    logic             w_idle;
    logic             w_grant_a;
    logic             w_grant_m;
    logic             w_accept;
    logic [TB_AW-1:0] w_addr;
    logic [CNT_W-1:0] w_len;
    logic [1:0]       w_dir;
    logic             w_lk0;
    logic             w_last_row;
    logic             w_drain_end;
    sel_t             w_push;
    sel_t             w_sel_out;

    assign w_idle = (r_state == ST_IDLE);

`ifdef TB_RD_SCHED_RR_EN
    logic r_rr_last;
    assign w_grant_a = a_req_valid && (!m_req_valid || (r_rr_last == TBa_M));
`else
    assign w_grant_a = a_req_valid;
`endif
    assign w_grant_m = m_req_valid && !w_grant_a;
    assign w_accept  = w_idle && (w_grant_a || w_grant_m);

    assign a_req_ready = w_idle && w_grant_a;
    assign m_req_ready = w_idle && w_grant_m;

    assign w_addr = w_grant_m ? m_req_addr : a_req_addr;
    assign w_len  = w_grant_m ? m_req_len  : a_req_len;
    assign w_dir  = w_grant_m ? m_req_dir  : a_req_dir;
    assign w_lk0  = w_grant_m ? m_req_lk0  : a_req_lk0;

    assign w_last_row  = ((r_cnt + CNT_ONE) == r_len);
    assign w_drain_end = (r_state == ST_DRAIN) && (r_drain == DRAIN_LAST);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_dir     <= DIR_IDLE;
            r_lk0     <= 1'b0;
            r_tgt     <= TBa_A;
            r_drain   <= '0;
`ifdef TB_RD_SCHED_RR_EN
            r_rr_last <= TBa_M;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_base <= w_addr;
                        r_len  <= w_len;
                        r_dir  <= w_dir;
                        r_lk0  <= w_lk0;
                        r_tgt  <= w_grant_m ? TBa_M : TBa_A;
                        r_cnt  <= '0;
`ifdef TB_RD_SCHED_RR_EN
                        r_rr_last <= w_grant_m ? TBa_M : TBa_A;
`endif
                        // A zero-length command has nothing in the delay line,
                        // so it skips straight to the final drain cycle.
                        if (w_len == '0) begin
                            r_state <= ST_DRAIN;
                            r_drain <= DRAIN_LAST;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (w_last_row) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // An IDLE direction reads rows but keeps the select at 000 so the
    // mapping stage emits zeros regardless of target.
    always_comb begin
        w_push = '0;
        if ((r_state == ST_ISSUE) && (r_dir != DIR_IDLE)) begin
            w_push.target = r_tgt;
            w_push.dir    = r_dir;
            w_push.lk0    = r_lk0;
        end
    end

    tb_sel_delay #(
        .RD_LAT (RD_LAT)
    ) u_sel_delay (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .i_sel (w_push),
        .o_sel (w_sel_out)
    );

    assign TB_ena       = (r_state == ST_ISSUE);
    assign TB_addra     = r_base + TB_AW'(r_cnt);
    assign TB_douta_sel = {w_sel_out.target, w_sel_out.dir};
    assign l_k_0        = w_sel_out.lk0;
    assign a_done       = w_drain_end && (r_tgt == TBa_A);
    assign m_done       = w_drain_end && (r_tgt == TBa_M);
    assign busy         = !w_idle;

endmodule

// File: tb/tb_tb_rd_sched.sv
// Scoreboard bench for tb_rd_sched: two instances (RD_LAT 1 and 3), directed
// commands push expected events, a negedge monitor pops and compares them.
module tb_tb_rd_sched;

    localparam int AW = 10;
    localparam int CW = 8;

    typedef struct {
        int d;
        int k;
        int c;
        int v;
    } exp_t;

    typedef struct {
        int d;
        int side;
        int c;
    } grant_t;

    exp_t   sb[$];
    grant_t glog[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    int     lat[2];

    logic clk       = 1'b0;
    logic sys_rst_n = 1'b0;

    logic          a_valid [2];
    logic          a_ready [2];
    logic [AW-1:0] a_addr  [2];
    logic [CW-1:0] a_len   [2];
    logic [1:0]    a_dir   [2];
    logic          a_lk0   [2];
    logic          m_valid [2];
    logic          m_ready [2];
    logic [AW-1:0] m_addr  [2];
    logic [CW-1:0] m_len   [2];
    logic [1:0]    m_dir   [2];
    logic          m_lk0   [2];
    logic          ena     [2];
    logic [AW-1:0] addra   [2];
    logic [2:0]    sel     [2];
    logic          lk      [2];
    logic          adone   [2];
    logic          mdone   [2];
    logic          busy    [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    tb_rd_sched #(.TB_AW(AW), .CNT_W(CW), .RD_LAT(1)) u_dut0 (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .a_req_valid(a_valid[0]), .a_req_ready(a_ready[0]), .a_req_addr(a_addr[0]),
        .a_req_len(a_len[0]), .a_req_dir(a_dir[0]), .a_req_lk0(a_lk0[0]),
        .m_req_valid(m_valid[0]), .m_req_ready(m_ready[0]), .m_req_addr(m_addr[0]),
        .m_req_len(m_len[0]), .m_req_dir(m_dir[0]), .m_req_lk0(m_lk0[0]),
        .TB_ena(ena[0]), .TB_addra(addra[0]), .TB_douta_sel(sel[0]), .l_k_0(lk[0]),
        .a_done(adone[0]), .m_done(mdone[0]), .busy(busy[0])
    );

    tb_rd_sched #(.TB_AW(AW), .CNT_W(CW), .RD_LAT(3)) u_dut1 (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .a_req_valid(a_valid[1]), .a_req_ready(a_ready[1]), .a_req_addr(a_addr[1]),
        .a_req_len(a_len[1]), .a_req_dir(a_dir[1]), .a_req_lk0(a_lk0[1]),
        .m_req_valid(m_valid[1]), .m_req_ready(m_ready[1]), .m_req_addr(m_addr[1]),
        .m_req_len(m_len[1]), .m_req_dir(m_dir[1]), .m_req_lk0(m_lk0[1]),
        .TB_ena(ena[1]), .TB_addra(addra[1]), .TB_douta_sel(sel[1]), .l_k_0(lk[1]),
        .a_done(adone[1]), .m_done(mdone[1]), .busy(busy[1])
    );

    function automatic string kname(input int k);
        case (k)
            0:       return "addr";
            1:       return "sel";
            2:       return "done";
            default: return "busy";
        endcase
    endfunction

    task automatic push(input int d, input int k, input int c, input int v);
        exp_t e;
        e.d = d; e.k = k; e.c = c; e.v = v;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int d, input int k, input int v);
        int idx;
        idx = -1;
        foreach (sb[i]) begin
            if (idx < 0 && sb[i].d == d && sb[i].k == k) idx = i;
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s dut%0d: got unexpected value %0h at cycle %0d, required none",
                     kname(k), d, v, cyc);
        end else begin
            if (sb[idx].c != cyc || sb[idx].v != v) begin
                errors++;
                $display("FAIL %s dut%0d: got %0h at cycle %0d, required %0h at cycle %0d",
                         kname(k), d, v, cyc, sb[idx].v, sb[idx].c);
            end
            sb.delete(idx);
        end
    endtask

    // Monitor: every non-idle DUT output is an event that must match the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ena[d])               check_ev(d, 0, int'(addra[d]));
            if (sel[d] != 3'b000 || lk[d]) check_ev(d, 1, int'({sel[d], lk[d]}));
            if (adone[d])             check_ev(d, 2, 0);
            if (mdone[d])             check_ev(d, 2, 1);
            if (busy[d])              check_ev(d, 3, 1);
        end
    end

    task automatic check_zero(input int d, input string name);
        logic [AW+7:0] got;
        got = {ena[d], addra[d], sel[d], lk[d], adone[d], mdone[d], busy[d]};
        checks++;
        if (got != '0) begin
            errors++;
            $display("FAIL %s dut%0d: outputs %0h, required 0", name, d, got);
        end
    endtask

    task automatic send(input int d, input int side, input int addr, input int len,
                        input int dir, input int lk0);
        int  w;
        int  acc;
        int  donec;
        bit  got;
        if (side == 0) begin
            a_addr[d] = addr[AW-1:0]; a_len[d] = len[CW-1:0];
            a_dir[d]  = dir[1:0];     a_lk0[d] = lk0[0];  a_valid[d] = 1'b1;
        end else begin
            m_addr[d] = addr[AW-1:0]; m_len[d] = len[CW-1:0];
            m_dir[d]  = dir[1:0];     m_lk0[d] = lk0[0];  m_valid[d] = 1'b1;
        end
        w   = 0;
        got = 1'b0;
        while (!got && w <= 100) begin
            @(negedge clk);
            if ((side == 0 && a_ready[d]) || (side == 1 && m_ready[d])) got = 1'b1;
            else w++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept dut%0d side%0d: got no ready in 100 cycles, required accept", d, side);
        end else begin
            acc = cyc;
            $display("accept dut%0d side=%0d addr=%03h len=%0d dir=%0d lk0=%0d cycle=%0d",
                     d, side, addr, len, dir, lk0, acc);
            for (int i = 0; i < len; i++) push(d, 0, acc + 1 + i, (addr + i) % (1 << AW));
            if (dir != 0)
                for (int i = 0; i < len; i++)
                    push(d, 1, acc + 1 + lat[d] + i, side * 8 + dir * 2 + lk0);
            donec = (len == 0) ? acc + 1 : acc + len + lat[d] + 1;
            push(d, 2, donec, side);
            for (int c = acc + 1; c <= donec; c++) push(d, 3, c, 1);
            glog.push_back('{d, side, acc});
        end
        @(posedge clk);
        #1;
        if (side == 0) a_valid[d] = 1'b0;
        else           m_valid[d] = 1'b0;
    endtask

    task automatic idle_wait();
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        int exp_order[3];
        int rc;
        lat[0] = 1;
        lat[1] = 3;
        for (int d = 0; d < 2; d++) begin
            a_valid[d] = 1'b0; a_addr[d] = '0; a_len[d] = '0; a_dir[d] = '0; a_lk0[d] = 1'b0;
            m_valid[d] = 1'b0; m_addr[d] = '0; m_len[d] = '0; m_dir[d] = '0; m_lk0[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0, "reset_state");
        check_zero(1, "reset_state");
        @(posedge clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // POS on A, RD_LAT 1
        send(0, 0, 'h010, 4, 1, 0);
        idle_wait();
        // NEG on M with address wrap
        send(0, 1, 'h3FE, 4, 2, 0);
        idle_wait();
        // NEW mode, lk0 = 1, RD_LAT 3
        send(1, 0, 'h100, 2, 3, 1);
        idle_wait();
        // zero-length command
        send(0, 0, 'h123, 0, 1, 0);
        idle_wait();
        // IDLE direction on M: reads issued, select stays zero
        send(0, 1, 'h050, 3, 0, 0);
        idle_wait();

        // Arbitration: both valid, A held valid for a second command
        glog.delete();
        fork
            begin
                send(0, 0, 'h020, 2, 1, 0);
                send(0, 0, 'h030, 2, 3, 0);
            end
            send(0, 1, 'h040, 1, 2, 0);
        join
        idle_wait();
`ifdef TB_RD_SCHED_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 1};
`endif
        check_val("grant_count", glog.size(), 3);
        if (glog.size() == 3) begin
            check_val("grant0_side", glog[0].side, exp_order[0]);
            check_val("grant1_side", glog[1].side, exp_order[1]);
            check_val("grant2_side", glog[2].side, exp_order[2]);
            check_val("back_to_back_gap", glog[1].c - glog[0].c, 5);
        end

        // Reset asserted in cycle 3 of a len-8 command
        glog.delete();
        send(0, 0, 'h100, 8, 1, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rc = (glog.size() > 0) ? glog[0].c + 3 : cyc;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].d == 0 && sb[i].c >= rc) sb.delete(i);
        sys_rst_n = 1'b0;
        @(negedge clk);
        check_zero(0, "mid_reset");
        @(posedge clk);
        #1 sys_rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(0, 0, 'h200, 3, 1, 0);
        idle_wait();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d unmatched events (first %s dut%0d cycle %0d), required 0",
                     sb.size(), kname(sb[0].k), sb[0].d, sb[0].c);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tb_rd_sched.md
# tb_rd_sched

Read scheduler for the TB buffer's port A and its output mapping stage. Two requesters, the A-side and M-side RSA operand loaders, submit row-block read commands. The block arbitrates between them, issues `TB_ena`/`TB_addra` for each row, and drives `TB_douta_sel`/`l_k_0` delayed by the BRAM read latency, so the mapping stage sees the correct select in the same cycle `TB_douta` carries the row.

## Interface
Parameters:
- `TB_AW`, 10: TB address width.
- `CNT_W`, 8: row-count width.
- `RD_LAT`, 1: TB port-A read latency in cycles. Legal range is 1..4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `a_req_valid`  in  1: A-side command valid.
- `a_req_ready`  out  1: A-side command accepted in this cycle when valid is also high.
- `a_req_addr`  in  TB_AW: first row address.
- `a_req_len`  in  CNT_W: number of rows; 0 is legal.
- `a_req_dir`  in  2: 00 IDLE, 01 POS, 10 NEG, 11 NEW.
- `a_req_lk0`  in  1: NEW-mode half select.
- `m_req_valid`, `m_req_ready`, `m_req_addr`, `m_req_len`, `m_req_dir`, `m_req_lk0`: same as the A-side ports, for the M-side.
- `TB_ena`  out  1: TB port-A read enable.
- `TB_addra`  out  TB_AW: TB port-A address.
- `TB_douta_sel`  out  3: bit 2 is target (0 = A, 1 = M); bits 1:0 are the direction.
- `l_k_0`  out  1: NEW half select, aligned with `TB_douta_sel`.
- `a_done`, `m_done`  out  1: one-cycle completion pulse per command.
- `busy`  out  1: a command is in flight.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - `X_req_ready` is combinational: high only for the granted requester, and only in IDLE.
  - On accept, latch addr, len, dir, lk0 and target into registers, and clear the counter.
  - If len ≠ 0, go to ISSUE.
  - If len = 0, go to DRAIN with zero rows, which produces an immediate done.
- ISSUE:
  - Each cycle: `TB_ena` = 1, `TB_addra` = base + cnt (mod 2^TB_AW), cnt++.
  - Push {target, dir, lk0} into the delay line.
  - Leave for DRAIN after issuing row len−1.
- DRAIN:
  - Push {0, 00, 0} into the delay line each cycle.
  - When the last row's select has left the delay line, pulse the `X_done` matching the latched target and return to IDLE.
- Delay line: RD_LAT stages. The stage output drives `TB_douta_sel` and `l_k_0`. Idle slots carry 000/0, which makes the mapping stage output zeros.
- Arbitration:
  - One valid requester: it is granted.
  - Both valid: the winner is set by the configuration macro (see Configuration).
- `busy` = state ≠ IDLE.
- Requester inputs are sampled only at accept. Changes to them afterwards have no effect.

## Timing
- Reset values: `TB_ena` 0, `TB_addra` 0, `TB_douta_sel` 000, `l_k_0` 0, `a_done`/`m_done` 0, `busy` 0, FSM IDLE, delay line all-zero, RR pointer = M (so A wins first).
- Accept at cycle 0 with len N ≥ 1:
  - `TB_ena` is high in cycles 1..N, with `TB_addra` = base+0 .. base+N−1.
  - `TB_douta_sel` is non-idle in cycles 1+RD_LAT .. N+RD_LAT.
  - `X_done` pulses in cycle N+RD_LAT+1.
  - `busy` is high in cycles 1 .. N+RD_LAT+1.
  - The next accept is possible in cycle N+RD_LAT+2 at the earliest.
- len = 0: no `TB_ena`; `X_done` in cycle 1; next accept in cycle 2 at the earliest.
- Address wrap: base + cnt wraps modulo 2^TB_AW with no error.
- dir = 00 accepted with N rows: reads are issued and the select stays 000, so the mapping stage outputs zeros. `done` pulses as normal.
- Reset deasserted mid-command: all state and the delay line clear immediately. The in-flight command is dropped with no done pulse, and the requester must resubmit.

## Configuration
- Macro: `TB_RD_SCHED_RR_EN`.
- Defined: round-robin. When both requesters are valid, grant the one not granted last. The pointer updates on every accept.
- Undefined: fixed priority, A over M. The RR pointer is not implemented.

## Structure
- Package `tb_sched_pkg` holds:
  - direction codes DIR_IDLE/POS/NEG/NEW = 00/01/10/11,
  - target codes TBa_A = 0 and TBa_M = 1,
  - FSM state encoding,
  - the {target, dir, lk0} select struct.
- Sub-module `tb_sel_delay`: an RD_LAT-stage shift register of the select struct with asynchronous active-low clear. It is shared with any future port-B scheduler.

## Test plan
- A-side command addr 0x010, len 4, dir 01, RD_LAT 1 → `TB_addra` 0x010..0x013 in cycles 1..4, `TB_douta_sel` = 001 in cycles 2..5, `a_done` in cycle 6.
- Both requesters valid in the same cycle, RR build → A granted first, then M. With A held valid after its done, M is still granted next. Fixed-priority build → A granted both times.
- M-side command addr 0x3FE, len 4, dir 10, TB_AW 10 → addresses 0x3FE, 0x3FF, 0x000, 0x001; `TB_douta_sel` = 110 throughout the data window.
- NEW mode, lk0 = 1, len 2, RD_LAT 3 → `TB_douta_sel` = 011 and `l_k_0` = 1 in cycles 4..5, 000/0 elsewhere.
- len 0 on A → no `TB_ena`, `a_done` in cycle 1, `busy` high only in cycle 1.
- Assert `sys_rst_n` low during cycle 3 of a len-8 command → all outputs return to their reset values immediately, no done pulse; a new command after release behaves normally.
